// File: rtl/exp_pkg.sv
// Shared definitions for the exponential unit (datapath and controller).
// Q2.14 constants, reciprocal coefficients and controller state codes.
package exp_pkg;

  localparam int DATA_W  = 16;
  localparam int FRAC_W  = 14;
  localparam int N_TERMS = 5;

  localparam logic [15:0] ONE = 16'h4000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INIT,
    ST_MUL,
    ST_ADD,
    ST_LD,
    ST_DONE
  } exp_state_e;

  // 1/(k+1) in Q2.14, rounded to nearest
  function automatic logic [15:0] coef_q14(
    input logic [2:0] k
  );
    logic [15:0] c;
    case (k)
      3'd0:    c = 16'd16384;
      3'd1:    c = 16'd8192;
      3'd2:    c = 16'd5461;
      3'd3:    c = 16'd4096;
      3'd4:    c = 16'd3277;
      3'd5:    c = 16'd2731;
      3'd6:    c = 16'd2341;
      default: c = 16'd2048;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/exp_datapath_if.sv
// Strobe/operand bundle between the exponential controller and datapath.
// The controller is the master; the datapath is the slave.
interface exp_datapath_if
  import exp_pkg::*;
#(
  parameter int DW = DATA_W
);

  logic          ldX;
  logic          ldTmp;
  logic          selTmp;
  logic [DW-1:0] x_in;
  logic          done;
  logic [DW-1:0] result;

  modport master (
    output ldX, ldTmp, selTmp, x_in,
    input  done, result
  );

  modport slave (
    input  ldX, ldTmp, selTmp, x_in,
    output done, result
  );

endinterface

// File: rtl/exp_coef_rom.sv
// Reciprocal coefficient lookup; index clamped to the last series term.
module exp_coef_rom
  import exp_pkg::*;
#(
  parameter int DW = DATA_W,
  parameter int NT = N_TERMS
) (
  input  logic [2:0]    idx,
  output logic [DW-1:0] coef
);

  localparam logic [2:0] IDX_MAX = 3'(NT - 2);

  logic [2:0] idx_c;

  always_comb begin
    idx_c = (idx > IDX_MAX) ? IDX_MAX : idx;
    coef  = DW'(coef_q14(idx_c));
  end

endmodule

// File: rtl/exp_datapath.sv
// e^x Taylor-series datapath: term/acc registers plus a free-running
// two-stage product pipeline feeding the next term.
module exp_datapath
  import exp_pkg::*;
#(
  parameter int DW = DATA_W,
  parameter int FW = FRAC_W,
  parameter int NT = N_TERMS
) (
  input  logic           clk,
  input  logic           rst,
  exp_datapath_if.slave  bus
);

  localparam logic [DW-1:0] ONE_L   = DW'(1) << FW;
  localparam logic [2:0]    CNT_MAX = 3'(NT - 1);
  localparam logic [2:0]    CNT_FIN = 3'(NT - 2);

  logic [DW-1:0] x_q, x_d;
  logic [DW-1:0] tmp_q, tmp_d;
  logic [DW-1:0] acc_q, acc_d;
  logic [DW-1:0] p1_q, p1_d;
  logic [DW-1:0] p2_q, p2_d;
  logic [2:0]    cnt_q, cnt_d;

  logic [DW-1:0]   coef;
  logic [2*DW-1:0] m1, m2;
  logic [DW:0]     sum;
  logic [DW-1:0]   sum_sat;

  exp_coef_rom #(
    .DW (DW),
    .NT (NT)
  ) u_rom (
    .idx  (cnt_q),
    .coef (coef)
  );

  always_comb begin
    m1      = (2*DW)'(tmp_q) * (2*DW)'(x_q);
    m2      = (2*DW)'(p1_q) * (2*DW)'(coef);
    p1_d    = DW'(m1 >> FW);
    p2_d    = DW'(m2 >> FW);
    sum     = {1'b0, acc_q} + {1'b0, p2_q};
    sum_sat = sum[DW] ? '1 : sum[DW-1:0];

    x_d   = bus.ldX ? bus.x_in : x_q;
    tmp_d = tmp_q;
    acc_d = acc_q;
    cnt_d = cnt_q;
    if (bus.ldTmp) begin
      if (bus.selTmp) begin
        tmp_d = ONE_L;
        acc_d = ONE_L;
        cnt_d = '0;
      end else begin
        tmp_d = p2_q;
        acc_d = sum_sat;
        // count sticks once the last term is in
        cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 3'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_q   <= '0;
      tmp_q <= '0;
      acc_q <= '0;
      cnt_q <= '0;
      p1_q  <= '0;
      p2_q  <= '0;
    end else begin
      x_q   <= x_d;
      tmp_q <= tmp_d;
      acc_q <= acc_d;
      cnt_q <= cnt_d;
      p1_q  <= p1_d;
      p2_q  <= p2_d;
    end
  end

  assign bus.done   = (cnt_q == CNT_FIN);
  assign bus.result = acc_q;

endmodule

// File: tb/tb_exp_datapath.sv
// Randomised and directed checks of exp_datapath against a
// term-by-term Taylor model of e^x in Q2.14.
module tb_exp_datapath;
  import exp_pkg::*;

  localparam int NT = N_TERMS;

  logic clk = 1'b0;
  logic rst;

  exp_datapath_if bus ();

  exp_datapath dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  longint m_x, m_term, m_acc, m_cnt;

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, exp);
    end
  endtask

  function automatic longint coef_of(input longint k);
    longint kk;
    kk = (k > NT - 2) ? NT - 2 : k;
    return (16384 + (kk + 1) / 2) / (kk + 1);
  endfunction

  task automatic idle(input int n);
    bus.ldX    = 1'b0;
    bus.ldTmp  = 1'b0;
    bus.selTmp = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_init(
    input logic [15:0] x,
    input bit          lx
  );
    bus.ldX    = lx;
    bus.ldTmp  = 1'b1;
    bus.selTmp = 1'b1;
    bus.x_in   = x;
    @(posedge clk);
    #1;
    bus.ldX   = 1'b0;
    bus.ldTmp = 1'b0;
    if (lx) m_x = longint'(x);
    m_term = 16384;
    m_acc  = 16384;
    m_cnt  = 0;
    check("init_result", bus.result, 32'(m_acc));
    check("init_done", 32'(bus.done), 32'(m_cnt == NT - 2));
  endtask

  task automatic do_step(input int gap);
    longint t1, t2;
    idle(gap);
    bus.ldTmp  = 1'b1;
    bus.selTmp = 1'b0;
    #1;
    check("step_done", 32'(bus.done), 32'(m_cnt == NT - 2));
    @(posedge clk);
    #1;
    bus.ldTmp = 1'b0;
    t1     = ((m_term * m_x) >> 14) & 64'hFFFF;
    t2     = ((t1 * coef_of(m_cnt)) >> 14) & 64'hFFFF;
    m_term = t2;
    m_acc  = (m_acc + t2 > 65535) ? 65535 : m_acc + t2;
    m_cnt  = (m_cnt + 1 > NT - 1) ? NT - 1 : m_cnt + 1;
    check("step_result", bus.result, 32'(m_acc));
  endtask

  initial begin
    logic [15:0] xs;
    bit          lx;
    int          nst;
    logic [15:0] acc_half [4];

    acc_half[0] = 16'h6000;
    acc_half[1] = 16'h6800;
    acc_half[2] = 16'h6955;
    acc_half[3] = 16'h697F;

    rst        = 1'b1;
    bus.ldX    = 1'b0;
    bus.ldTmp  = 1'b0;
    bus.selTmp = 1'b0;
    bus.x_in   = '0;
    m_x = 0; m_term = 0; m_acc = 0; m_cnt = 0;

    repeat (2) @(posedge clk);
    #1;
    check("rst_result", bus.result, 32'h0);
    check("rst_done", 32'(bus.done), 32'h0);
    rst = 1'b0;
    idle(3);
    check("idle_result", bus.result, 32'h0);
    check("idle_done", 32'(bus.done), 32'h0);

    do_init(16'h0000, 1'b1);
    for (int s = 0; s < NT - 1; s++) do_step(2);
    check("x0_final", bus.result, 32'h4000);

    do_init(16'h2000, 1'b1);
    for (int s = 0; s < NT - 1; s++) begin
      do_step(2);
      check("xhalf_acc", bus.result, 32'(acc_half[s]));
    end

    do_init(16'h4000, 1'b1);
    for (int s = 0; s < NT - 1; s++) do_step(2);
    check("x1_final", bus.result, 32'hAD54);

    do_init(16'h2000, 1'b1);
    do_step(2);
    do_step(2);
    #2;
    rst = 1'b1;
    #1;
    check("arst_result", bus.result, 32'h0);
    check("arst_done", 32'(bus.done), 32'h0);
    @(posedge clk);
    #1;
    check("arst_hold", bus.result, 32'h0);
    rst = 1'b0;
    m_x = 0; m_term = 0; m_acc = 0; m_cnt = 0;
    idle(1);

    do_init(16'h4000, 1'b1);
    for (int s = 0; s < NT - 1; s++) do_step(2);
    check("post_rst_final", bus.result, 32'hAD54);
    do_step(2);
    idle(2);
    check("after_extra_done", 32'(bus.done), 32'h0);

    do_init(16'h1234, 1'b0);
    for (int s = 0; s < NT - 1; s++) do_step(2);
    check("reinit_final", bus.result, 32'hAD54);

    do_init(16'hFFFF, 1'b1);
    for (int s = 0; s < NT - 1; s++) do_step(2);
    check("sat_final", bus.result, 32'hFFFF);

    for (int i = 0; i < 25; i++) begin
      if ($urandom_range(0, 3) == 0) xs = 16'($urandom_range(0, 16'hFFFF));
      else xs = 16'($urandom_range(0, 16'h4000));
      lx  = ($urandom_range(0, 4) != 0);
      nst = NT - 1 + int'($urandom_range(0, 2));
      do_init(xs, lx);
      for (int s = 0; s < nst; s++) do_step(int'($urandom_range(2, 4)));
      idle(int'($urandom_range(0, 3)));
      check("rand_hold", bus.result, 32'(m_acc));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
